// File: rtl/matvec_core.sv
// Matrix-vector multiply stage: loads W (N x N, row-major) then x (N) from the
// fetch stream, computes y = W*x with one signed MAC per cycle, then streams y out.
module matvec_core #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  src_vld,
    output logic                  src_rdy,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  res_vld,
    input  logic                  res_rdy,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  res_last,
    output logic                  busy,
    output logic                  done
);

    localparam int W_DEPTH = N*N;
    localparam int IDX_W   = $clog2(W_DEPTH);
    localparam int RC_W    = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] W_LAST  = IDX_W'(W_DEPTH-1);
    localparam logic [IDX_W-1:0] X_LAST  = IDX_W'(N-1);
    localparam logic [RC_W-1:0]  RC_LAST = RC_W'(N-1);

    typedef enum logic [1:0] {
        LOAD_W,
        LOAD_X,
        COMPUTE,
        OUTPUT
    } state_t;

    state_t state, state_next;

    logic [IDX_W-1:0]            idx;
    logic [RC_W-1:0]             row, col, out_idx;
    logic signed [ACC_WIDTH-1:0] acc, acc_next, w_ext, x_ext, prod;
    logic [IDX_W-1:0]            w_addr;

    logic signed [DATA_WIDTH-1:0] w_mem [W_DEPTH];
    logic signed [DATA_WIDTH-1:0] x_mem [N];
    logic signed [ACC_WIDTH-1:0]  y_mem [N];

    logic w_wr, x_wr, row_end, mac_last, res_hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_W;
        end else begin
            state <= state_next;
        end
    end

    // src_rdy comes from state alone so the fetch engine can tie its response ready to it
    always_comb begin
        state_next = state;
        src_rdy    = 1'b0;
        res_vld    = 1'b0;
        busy       = 1'b0;
        w_wr       = 1'b0;
        x_wr       = 1'b0;
        res_hs     = 1'b0;
        row_end    = (col == RC_LAST);
        mac_last   = row_end && (row == RC_LAST);
        case (state)
            LOAD_W: begin
                src_rdy = 1'b1;
                w_wr    = src_vld;
                if (src_vld && idx == W_LAST) state_next = LOAD_X;
            end
            LOAD_X: begin
                src_rdy = 1'b1;
                x_wr    = src_vld;
                if (src_vld && idx == X_LAST) state_next = COMPUTE;
            end
            COMPUTE: begin
                busy = 1'b1;
                if (mac_last) state_next = OUTPUT;
            end
            OUTPUT: begin
                busy    = 1'b1;
                res_vld = 1'b1;
                res_hs  = res_rdy;
                if (res_rdy && out_idx == RC_LAST) state_next = LOAD_W;
            end
            default: state_next = LOAD_W;
        endcase
    end

    assign w_addr   = IDX_W'(int'(row) * N + int'(col));
    assign w_ext    = ACC_WIDTH'(w_mem[w_addr]);
    assign x_ext    = ACC_WIDTH'(x_mem[col]);
    assign prod     = w_ext * x_ext;
    assign acc_next = acc + prod;

    assign res_data = (state == OUTPUT) ? y_mem[out_idx] : '0;
    assign res_last = (state == OUTPUT) && (out_idx == RC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            row     <= '0;
            col     <= '0;
            out_idx <= '0;
            acc     <= '0;
            done    <= 1'b0;
        end else begin
            done <= res_hs && (out_idx == RC_LAST);
            case (state)
                LOAD_W: begin
                    if (w_wr) idx <= (idx == W_LAST) ? '0 : idx + IDX_W'(1);
                end
                LOAD_X: begin
                    if (x_wr) begin
                        if (idx == X_LAST) begin
                            idx <= '0;
                            row <= '0;
                            col <= '0;
                            acc <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (row_end) begin
                        acc <= '0;
                        col <= '0;
                        row <= (row == RC_LAST) ? '0 : row + RC_W'(1);
                    end else begin
                        acc <= acc_next;
                        col <= col + RC_W'(1);
                    end
                    if (mac_last) out_idx <= '0;
                end
                OUTPUT: begin
                    if (res_hs) begin
                        if (out_idx == RC_LAST) begin
                            out_idx <= '0;
                            idx     <= '0;
                        end else begin
                            out_idx <= out_idx + RC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is intentionally unreset; contents are rewritten before every use
    always_ff @(posedge clk) begin
        if (w_wr) w_mem[idx] <= src_data;
        if (x_wr) x_mem[idx[RC_W-1:0]] <= src_data;
        if (state == COMPUTE && row_end) y_mem[row] <= acc_next;
    end

endmodule

// File: doc/matvec_core.md
Name: matvec_core

Overview:
- Consumer stage directly downstream of the fetch engine.
- Accepts the fetched stream over a valid/ready handshake: first the weight matrix W (N×N words, row-major), then the input vector x (N words).
- Computes y = W·x as signed integer arithmetic with one MAC per cycle.
- Emits the N results on a valid/ready result stream; `res_last` marks the final word.

Parameters:
- DATA_WIDTH, 8, width of one W/x element (signed two's complement); must match the fetch engine data width.
- N, 4, matrix dimension; W_DEPTH = N*N = 16, X_DEPTH = N = 4.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N) = 18, accumulator and result width (signed).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- src_vld  input  1  stream word valid from the fetch engine
- src_rdy  output  1  core ready to accept a stream word
- src_data  input  DATA_WIDTH  stream word (W then x)
- res_vld  output  1  result word valid
- res_rdy  input  1  downstream ready for result
- res_data  output  ACC_WIDTH  result y[r], signed
- res_last  output  1  high with res_vld on y[N-1]
- busy  output  1  high in COMPUTE and OUTPUT
- done  output  1  one-cycle pulse after the final result handshake

Behaviour:
- Reset (async, rst_n low):
  - state=LOAD_W; all counters 0; accumulator 0.
  - Outputs: src_rdy=1, res_vld=0, res_data=0, res_last=0, busy=0, done=0.
  - W/x/y storage contents are don't-care after reset.
- Handshake:
  - A transfer occurs on a rising edge where vld && rdy.
  - src_rdy is decoded from state only: 1 in LOAD_W/LOAD_X, 0 otherwise. It never depends combinationally on src_vld, because the fetch engine ties its memory-response ready to src_rdy.
- LOAD_W:
  - Each accepted word is written to W[idx], idx 0..N*N-1 (row r=idx/N, col c=idx%N).
  - On accepting idx=N*N-1: go to LOAD_X, idx=0.
  - Cycles with src_vld=0 are stalls with no state change.
- LOAD_X:
  - Each accepted word is written to x[idx].
  - On accepting idx=N-1: go to COMPUTE; r=0, c=0, acc=0; src_rdy drops the next cycle.
- COMPUTE, one MAC per cycle:
  - acc_next = acc + sext(W[r][c])*sext(x[c]), full ACC_WIDTH signed.
  - If c==N-1: y[r]<=acc_next, acc<=0, c<=0, r<=r+1; otherwise acc<=acc_next, c<=c+1.
  - Takes exactly N*N cycles (16 at defaults).
  - After the edge completing r=N-1,c=N-1: go to OUTPUT, out_idx=0, res_vld=1.
- Arithmetic:
  - ACC_WIDTH guarantees no overflow for any inputs, worst case N*(−2^(DATA_WIDTH−1))^2.
  - No saturation and no truncation.
- OUTPUT:
  - res_data=y[out_idx]; res_last=(out_idx==N-1).
  - res_vld, res_data and res_last hold stable while res_rdy=0.
  - On handshake: out_idx++.
  - On handshake of the last word: res_vld=0, done=1 for one cycle, state→LOAD_W, idx=0.
- Latency:
  - Last x accepted at edge E → res_vld first high after edge E+N*N (E+16).
  - With res_rdy held high, results occupy N consecutive cycles.
- Back-to-back:
  - src_rdy returns high in the cycle after the final result handshake; the next W stream may start immediately.
  - There is no overlap of loading and computing.
- Boundary conditions:
  - Words presented during COMPUTE/OUTPUT are not accepted (src_rdy=0); the producer must hold them.
  - Reset asserted mid-load, mid-compute or mid-output aborts immediately to the reset state; partial data is discarded, and no done or res_vld glitch occurs after reset release.
- Fetch engine inter-op requirement: with the fetch engine issuing W_DEPTH=N*N then X_DEPTH=N words per RUN, one RUN produces exactly one result burst.

Test Plan:
- Identity: W=I (1 on diagonal, else 0), x={1,2,3,4}, res_rdy=1 → res_data 1,2,3,4 on 4 consecutive cycles; res_last with 4; done pulse 1 cycle later; first res_vld 16 cycles after last x edge.
- Signed worst case: all W=−128, all x=−128 → every y=65536 (0x10000 in 18 bits); all W=127, all x=−128 → every y=−65024.
- General: W row r = {r+1, −1, 2, 0}, x={3,5,−7,9} → y = 3(r+1)−5−14 = {−16,−13,−10,−7}.
- Source stalls: src_vld toggled randomly (50%) across all 20 words → identical results to the no-stall run; no word dropped or duplicated; src_rdy=0 throughout COMPUTE/OUTPUT.
- Result backpressure: res_rdy low for 5 cycles on each result → res_data/res_last stable while stalled; done only after the 4th handshake; then a second back-to-back matrix produces correct new results.
- Reset mid-COMPUTE (cycle 7) then a full new load of the identity case → outputs 1,2,3,4 with no stale values; all outputs at reset values while rst_n is low.
